fxp_activation_unit: RTL and testbench
======================================

FXP_ACTIVATION_UNIT -- requirements
Module: fxp_activation_unit

Interface
REQ-001 Parameter WIDTH, default 64, total signed fixed-point width in bits.
REQ-002 Parameter FRAC, default 32, fractional bits; SHALL satisfy 1 <= FRAC < WIDTH.
REQ-003 Parameter EXP_TERMS, default 20, number of Taylor-series terms of exp, including the constant term; SHALL be >= 2.
REQ-004 Parameter SIG_SAT, default 6, integer saturation bound for Sigmoid.
REQ-005 Parameter TANH_SAT, default 3, integer saturation bound for Tanh.
REQ-006 clk  in  1  single clock; all logic updates on the rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 in_valid  in  1  input operand valid.
REQ-009 in_ready  out  1  unit can accept an operand.
REQ-010 in_data  in  WIDTH  signed operand x, FRAC fractional bits.
REQ-011 in_func  in  2  activation select: 0 Step, 1 Sigmoid, 2 Tanh, 3 ReLU.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_data  out  WIDTH  signed result, same format as in_data.
REQ-015 busy  out  1  high in every state other than IDLE.

Function
REQ-016 Accept SHALL occur on an edge where in_valid && in_ready; in_data and in_func SHALL be latched at that edge; in_ready SHALL be high iff state==IDLE && !out_valid.
REQ-017 FSM states: IDLE, MUL, DIV, DONE; DONE SHALL hold out_valid high and keep out_data stable until out_valid && out_ready, then return to IDLE.
REQ-018 Step: x >= 0 -> ONE (1<<FRAC), else 0; ReLU: max(x,0); both SHALL reach DONE with out_valid high on the first edge after accept.
REQ-019 Sigmoid: x > SIG_SAT -> ONE; x < -SIG_SAT -> 0; both SHALL take a latency of 1 cycle. Otherwise the result SHALL be 1/(1+exp(-x)).
REQ-020 Tanh: x > TANH_SAT -> ONE; x < -TANH_SAT -> -ONE; both SHALL take a latency of 1 cycle. Otherwise the result SHALL be 2/(1+exp(-2x)) - 1, with the subtraction applied at the DONE load.
REQ-021 exp(a) SHALL be computed iteratively: term=result=ONE; for i=1..EXP_TERMS-1: term=div(mul(term,a), i<<FRAC); result+=term.
REQ-022 Each series step SHALL take 1 MUL cycle plus WIDTH DIV cycles; the final reciprocal division SHALL take WIDTH DIV cycles plus 1 load cycle.
REQ-023 Non-saturated latency from accept edge to out_valid SHALL be exactly EXP_TERMS*(WIDTH+1) cycles, which is 1300 at the defaults.
REQ-024 mul SHALL form the full 2*WIDTH signed product, arithmetic-shift it right by FRAC, and truncate to WIDTH bits.
REQ-025 div SHALL be a restoring divider of |a|<<FRAC by |b|, producing one quotient bit per cycle, MSB first, with sign = sign(a) XOR sign(b).
REQ-026 div with b==0 SHALL return the maximum positive value if a >= 0, else the minimum negative value; div with a==0 SHALL return 0; both SHALL still consume WIDTH cycles.
REQ-027 The unit SHALL hold a single operation in flight; in_valid SHALL be ignored while in_ready is low.
REQ-028 When out_ready is already high at the edge DONE is entered, the handshake SHALL complete on the next edge.

Reset
REQ-029 On an rst-high edge: state=IDLE, out_valid=0, out_data=0, busy=0, all datapath registers cleared, and any in-flight operation discarded.
REQ-030 in_ready SHALL be 1 on the first edge after rst deasserts; rst asserted mid-operation SHALL produce no out_valid pulse.

Configuration
REQ-031 Macro FXP_ACT_OVF_EN defined: add port out_ovf (out, 1), valid with out_valid. It SHALL be set if, during the operation, any mul had truncated bits that were not a sign extension, or any div hit b==0. It SHALL be cleared on accept and on reset.
REQ-032 Macro FXP_ACT_OVF_EN undefined: out_ovf and its logic are absent; all other behaviour is identical.

Verification (WIDTH=64, FRAC=32, ONE=0x1_00000000)
REQ-033 ReLU x=-3.0 -> out_data 0; x=2.5 -> 0x2_80000000; in both cases out_valid is high 1 cycle after accept.
REQ-034 Sigmoid x=0 -> out_data within 0x2a of 0x80000000, with out_valid exactly 1300 cycles after accept.
REQ-035 Sigmoid x=7.0 -> ONE and x=-7.0 -> 0; Tanh x=-4.0 -> 0xFFFFFFFF_00000000; all at a latency of 1 cycle.
REQ-036 Tanh x=1.0 -> out_data within 2^-20 of 0.761594 (about 0xC2F7D5AB).
REQ-037 out_ready held low 10 cycles in DONE -> out_data stable and in_ready low; a concurrent in_valid is not accepted; in_ready rises 1 cycle after the handshake.
REQ-038 rst pulsed at cycle 500 of a Sigmoid operation -> no out_valid, out_data 0, in_ready 1 the edge after rst falls; with FXP_ACT_OVF_EN, Sigmoid x=-5.9 -> out_ovf reflects overflow status.

Source files
------------

// File: rtl/fxp_activation_unit_if.sv
// rtl/fxp_activation_unit_if.sv - operand/result handshake bundle for fxp_activation_unit; out_ovf exists only with FXP_ACT_OVF_EN
interface fxp_activation_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_func;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef FXP_ACT_OVF_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_func, out_ready,
        input  in_ready, out_valid, out_data, busy, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_func, out_ready,
        output in_ready, out_valid, out_data, busy, out_ovf
    );
`else
    modport master (
        output in_valid, in_data, in_func, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_func, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif
endinterface

// File: rtl/fxp_activation_unit.sv
// rtl/fxp_activation_unit.sv - fixed-point Step/Sigmoid/Tanh/ReLU via Taylor exp and bit-serial divide; FXP_ACT_OVF_EN adds out_ovf
module fxp_activation_unit #(
    parameter int WIDTH     = 64,
    parameter int FRAC      = 32,
    parameter int EXP_TERMS = 20,
    parameter int SIG_SAT   = 6,
    parameter int TANH_SAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    fxp_activation_unit_if.slave act
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int IDX_W = $clog2(EXP_TERMS + 1);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]        ONE     = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0]        MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]        MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] SIG_HI  = WIDTH'(SIG_SAT) << FRAC;
    localparam logic signed [WIDTH-1:0] TANH_HI = WIDTH'(TANH_SAT) << FRAC;
    localparam logic [1:0] F_STEP = 2'd0, F_SIG = 2'd1, F_TANH = 2'd2, F_RELU = 2'd3;

    state_t                   state_q, state_d;
    logic [1:0]               func_q;
    logic signed [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]         a_q, term_q, sum_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     recip_q;
    logic [WIDTH-1:0]         rem_q, num_q, den_q, quo_q;
    logic                     div_neg_q, div_bzero_q, div_azero_q, div_aneg_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [WIDTH-1:0]         out_data_q;
    logic                     out_valid_q;

    logic                     in_ready, accept;
    logic signed [2*WIDTH-1:0] term_ext, a_ext, product;
    logic [WIDTH-1:0]         mul_res;
    logic                     mul_ovf;
    logic [WIDTH:0]           rem_shift, rem_diff;
    logic                     rem_ge;
    logic [WIDTH-1:0]         rem_next, quo_next, div_res, sum_next;
    logic                     div_last, step_last;
    logic                     simple_op;
    logic [WIDTH-1:0]         simple_res, recip_res;
    logic                     div_start;
    logic [WIDTH-1:0]         start_a, start_b, abs_a, abs_b;
    logic                     unused_bits;

    assign in_ready      = (state_q == IDLE) && !out_valid_q;
    assign accept        = act.in_valid && in_ready;
    assign act.in_ready  = in_ready;
    assign act.out_valid = out_valid_q;
    assign act.out_data  = out_data_q;
    assign act.busy      = (state_q != IDLE);
    assign unused_bits   = ^{product[FRAC-1:0], rem_diff[WIDTH], mul_ovf};

    always_comb begin
        term_ext = {{WIDTH{term_q[WIDTH-1]}}, term_q};
        a_ext    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        product  = term_ext * a_ext;
        mul_res  = product[WIDTH+FRAC-1:FRAC];
        // Bits dropped above the kept word must all replicate its sign bit.
        mul_ovf  = (product[2*WIDTH-1:WIDTH+FRAC-1] != '0) &&
                   (product[2*WIDTH-1:WIDTH+FRAC-1] != '1);

        rem_shift = {rem_q, num_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, den_q};
        rem_ge    = (rem_shift >= {1'b0, den_q});
        rem_next  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], rem_ge};
        if (div_bzero_q)
            div_res = div_aneg_q ? MIN_NEG : MAX_POS;
        else if (div_azero_q)
            div_res = '0;
        else if (div_neg_q)
            div_res = -quo_next;
        else
            div_res = quo_next;
        sum_next  = sum_q + div_res;
        div_last  = (cnt_q == CNT_W'(WIDTH - 1));
        step_last = (idx_q == IDX_W'(EXP_TERMS - 1));

        simple_op  = 1'b0;
        simple_res = '0;
        case (func_q)
            F_STEP: begin
                simple_op  = 1'b1;
                simple_res = x_q[WIDTH-1] ? '0 : ONE;
            end
            F_RELU: begin
                simple_op  = 1'b1;
                simple_res = x_q[WIDTH-1] ? '0 : x_q;
            end
            F_SIG: begin
                if (x_q > SIG_HI) begin
                    simple_op  = 1'b1;
                    simple_res = ONE;
                end else if (x_q < -SIG_HI) begin
                    simple_op  = 1'b1;
                end
            end
            default: begin
                if (x_q > TANH_HI) begin
                    simple_op  = 1'b1;
                    simple_res = ONE;
                end else if (x_q < -TANH_HI) begin
                    simple_op  = 1'b1;
                    simple_res = -ONE;
                end
            end
        endcase
        recip_res = (func_q == F_TANH) ? term_q - ONE : term_q;

        // The divider is started either for a series step or, straight from the
        // last step, for the final reciprocal so no extra cycle is spent.
        div_start = 1'b0;
        start_a   = '0;
        start_b   = '0;
        if (state_q == MUL && !simple_op && !recip_q) begin
            div_start = 1'b1;
            start_a   = mul_res;
            start_b   = WIDTH'(idx_q) << FRAC;
        end else if (state_q == DIV && div_last && !recip_q && step_last) begin
            div_start = 1'b1;
            start_a   = (func_q == F_TANH) ? ONE << 1 : ONE;
            start_b   = ONE + sum_next;
        end
        abs_a = start_a[WIDTH-1] ? -start_a : start_a;
        abs_b = start_b[WIDTH-1] ? -start_b : start_b;

        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MUL;
            MUL:     state_d = (simple_op || recip_q) ? DONE : DIV;
            DIV:     if (div_last && (recip_q || !step_last)) state_d = MUL;
            DONE:    if (act.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            func_q      <= '0;
            x_q         <= '0;
            a_q         <= '0;
            term_q      <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            recip_q     <= 1'b0;
            rem_q       <= '0;
            num_q       <= '0;
            den_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            div_neg_q   <= 1'b0;
            div_bzero_q <= 1'b0;
            div_azero_q <= 1'b0;
            div_aneg_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        func_q  <= act.in_func;
                        x_q     <= act.in_data;
                        a_q     <= (act.in_func == F_TANH) ? -(act.in_data << 1) : -act.in_data;
                        term_q  <= ONE;
                        sum_q   <= ONE;
                        idx_q   <= IDX_W'(1);
                        recip_q <= 1'b0;
                    end
                end
                MUL: begin
                    if (simple_op) begin
                        out_data_q  <= simple_res;
                        out_valid_q <= 1'b1;
                    end else if (recip_q) begin
                        out_data_q  <= recip_res;
                        out_valid_q <= 1'b1;
                    end
                end
                DIV: begin
                    rem_q <= rem_next;
                    num_q <= num_q << 1;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (div_last) begin
                        term_q <= div_res;
                        if (!recip_q) begin
                            sum_q   <= sum_next;
                            idx_q   <= idx_q + IDX_W'(1);
                            recip_q <= step_last;
                        end
                    end
                end
                DONE: begin
                    if (act.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
            if (div_start) begin
                rem_q       <= abs_a >> (WIDTH - FRAC);
                num_q       <= abs_a << FRAC;
                den_q       <= abs_b;
                quo_q       <= '0;
                cnt_q       <= '0;
                div_neg_q   <= start_a[WIDTH-1] ^ start_b[WIDTH-1];
                div_bzero_q <= (start_b == '0);
                div_azero_q <= (start_a == '0);
                div_aneg_q  <= start_a[WIDTH-1];
            end
        end
    end

`ifdef FXP_ACT_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst || accept)
            ovf_q <= 1'b0;
        else if (div_start && ((state_q == MUL && mul_ovf) || start_b == '0))
            ovf_q <= 1'b1;
    end

    assign act.out_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_fxp_activation_unit.sv
// tb/tb_fxp_activation_unit.sv - randomized self-checking bench for fxp_activation_unit against a wide-integer arithmetic model
module tb_fxp_activation_unit;
    localparam int W        = 64;
    localparam int F        = 32;
    localparam int TERMS    = 20;
    localparam int LAT_FULL = TERMS * (W + 1);
    localparam logic [63:0] ONE = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   m_ovf;
    logic [63:0] last_out;

    fxp_activation_unit_if #(.WIDTH(W)) bus ();

    fxp_activation_unit #(
        .WIDTH(W), .FRAC(F), .EXP_TERMS(TERMS), .SIG_SAT(6), .TANH_SAT(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .act (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] m_mul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] p;
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        p = p >>> F;
        if (p > 128'sh7FFF_FFFF_FFFF_FFFF || p < -128'sh8000_0000_0000_0000) m_ovf = 1'b1;
        return p[63:0];
    endfunction

    function automatic logic [63:0] m_div(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ua, ub, q;
        if (b == 64'd0) begin
            m_ovf = 1'b1;
            return a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        end
        if (a == 64'd0) return 64'd0;
        ua = {64'd0, a[63] ? -a : a};
        ub = {64'd0, b[63] ? -b : b};
        q  = (ua << F) / ub;
        if (a[63] ^ b[63]) q = -q;
        return q[63:0];
    endfunction

    function automatic logic [63:0] m_exp(input logic [63:0] a);
        logic [63:0] term, res;
        term = ONE;
        res  = ONE;
        for (int i = 1; i < TERMS; i++) begin
            term = m_div(m_mul(term, a), 64'(i) << F);
            res  = res + term;
        end
        return res;
    endfunction

    task automatic m_act(input logic [1:0] f, input logic [63:0] x,
                         output logic [63:0] d, output int lat);
        longint sx;
        sx    = x;
        m_ovf = 1'b0;
        lat   = 1;
        case (f)
            2'd0: d = (sx >= 0) ? ONE : 64'd0;
            2'd3: d = (sx < 0) ? 64'd0 : x;
            2'd1: begin
                if (sx > (longint'(6) <<< F))       d = ONE;
                else if (sx < -(longint'(6) <<< F)) d = 64'd0;
                else begin
                    d   = m_div(ONE, ONE + m_exp(-x));
                    lat = LAT_FULL;
                end
            end
            default: begin
                if (sx > (longint'(3) <<< F))       d = ONE;
                else if (sx < -(longint'(3) <<< F)) d = -ONE;
                else begin
                    d   = m_div(ONE * 2, ONE + m_exp(-(x * 2))) - ONE;
                    lat = LAT_FULL;
                end
            end
        endcase
    endtask

    task automatic do_op(input logic [1:0] f, input logic [63:0] x, input int hold, input string tag);
        logic [63:0] want;
        int          want_lat;
        bit          want_ovf;
        int          lat;
        m_act(f, x, want, want_lat);
        want_ovf = m_ovf;
        @(negedge clk);
        check({tag, ".in_ready"}, bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.in_func   = f;
        bus.in_data   = x;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, ".busy"}, bus.busy, 1);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, lat, want_lat);
        check({tag, ".data"}, bus.out_data, want);
`ifdef FXP_ACT_OVF_EN
        check({tag, ".ovf"}, bus.out_ovf, want_ovf);
`endif
        last_out = bus.out_data;
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'b1;
            bus.in_func  = 2'd3;
            bus.in_data  = 64'h5_0000_0000;
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, bus.out_valid, 1);
            check({tag, ".hold_data"}, bus.out_data, want);
            check({tag, ".hold_ready"}, bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".post_valid"}, bus.out_valid, 0);
        check({tag, ".post_ready"}, bus.in_ready, 1);
        check({tag, ".post_busy"}, bus.busy, 0);
    endtask

    initial begin
        longint diff;
        int     pulses;
        logic [31:0] r;
        bus.in_valid  = 1'b0;
        bus.in_func   = 2'd0;
        bus.in_data   = 64'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset.out_valid", bus.out_valid, 0);
        check("reset.out_data", bus.out_data, 0);
        check("reset.busy", bus.busy, 0);
        check("reset.in_ready", bus.in_ready, 1);

        do_op(2'd3, 64'hFFFF_FFFD_0000_0000, 0, "relu_m3");
        check("relu_m3.spec", last_out, 64'd0);
        do_op(2'd3, 64'h2_8000_0000, 0, "relu_2p5");
        check("relu_2p5.spec", last_out, 64'h2_8000_0000);
        do_op(2'd0, 64'd0, 0, "step_0");
        check("step_0.spec", last_out, ONE);
        do_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "step_neg");
        do_op(2'd1, 64'd0, 0, "sig_0");
        diff = $signed(last_out) - 64'sh8000_0000;
        check("sig_0.tol", (diff <= 42 && diff >= -42), 1);
        do_op(2'd1, 64'h7_0000_0000, 0, "sig_p7");
        check("sig_p7.spec", last_out, ONE);
        do_op(2'd1, 64'hFFFF_FFF9_0000_0000, 0, "sig_m7");
        check("sig_m7.spec", last_out, 64'd0);
        do_op(2'd2, 64'hFFFF_FFFC_0000_0000, 0, "tanh_m4");
        check("tanh_m4.spec", last_out, 64'hFFFF_FFFF_0000_0000);
        do_op(2'd2, ONE, 0, "tanh_1");
        diff = $signed(last_out) - 64'sh0_C2F7_D5AB;
        check("tanh_1.tol", (diff <= 4096 && diff >= -4096), 1);
        do_op(2'd1, 64'h6_0000_0000, 0, "sig_edge_in");
        do_op(2'd1, 64'h6_0000_0001, 0, "sig_edge_out");
        do_op(2'd2, 64'hFFFF_FFFD_0000_0000, 0, "tanh_edge_in");
        do_op(2'd1, 64'hFFFF_FFFA_1999_999A, 0, "sig_m5p9");
        do_op(2'd3, 64'h2_8000_0000, 10, "backpressure");

        for (int n = 0; n < 16; n++) begin
            r = $urandom;
            do_op(2'($urandom_range(0, 3)), {{28{r[31]}}, r, 4'b0000},
                  int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
        end

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_func  = 2'd1;
        bus.in_data  = 64'd0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (499) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst.out_valid", bus.out_valid, 0);
        check("midrst.out_data", bus.out_data, 0);
        check("midrst.in_ready", bus.in_ready, 1);
        check("midrst.busy", bus.busy, 0);
        pulses = 0;
        repeat (1400) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) pulses++;
        end
        check("midrst.no_valid", pulses, 0);
        do_op(2'd3, 64'h2_8000_0000, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
